snf_sram_model: RTL
===================

# snf_sram_model

Parametrised, queued memory model for the SNF side of the NoC test environment. It accepts read/write requests over a valid/ready channel, buffers them in a request queue, and executes them in order against a word-addressed array with byte enables. It returns one response per request after a fixed read latency, through a response buffer that absorbs back-pressure. It exposes queue occupancy and full/empty status for bench checking.

## Interface
- `DATA_W`, 512: data width in bits; multiple of 8.
- `ADDR_W`, 44: request byte-address width.
- `DEPTH`, 64: memory words; power of two.
- `QDEPTH`, 4: request queue entries; power of two, ≥2.
- `RD_LAT`, 1: issue-to-response pipeline stages, 1..4.
- `RSP_DEPTH`, 4: response buffer entries; must be ≥ `RD_LAT`+1.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset), synchronous deassert by the environment.
- `req_valid` in 1: request present.
- `req_ready` out 1: queue can accept; equals !`full`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in `DATA_W`: write data.
- `req_be` in `DATA_W`/8: byte enables; ignored for reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_write` out 1: response belongs to a write (ack).
- `rsp_rdata` out `DATA_W`: read data; 0 for writes.
- `rsp_err` out 1: address out of range.
- `full` out 1: request queue holds `QDEPTH` entries.
- `empty` out 1: request queue holds 0 entries.
- `count` out log2(`QDEPTH`)+1: request queue occupancy.

## Operation
- Word index = `req_addr` >> log2(`DATA_W`/8). An index ≥ `DEPTH` is out of range.
- A request is accepted on a cycle with `req_valid`&&`req_ready`, then pushed to the request queue.
- Issue: the head is popped when the queue is not empty and `outstanding` < `RSP_DEPTH`. `outstanding` = pipeline entries + response buffer entries. The block issues at most one request per cycle, strictly in order.
- Write issue: bytes with `req_be`=1 are written at the issue edge; other bytes are kept. An out-of-range write changes nothing and responds with `rsp_err`=1.
- Read issue: the array is sampled at the issue edge. An out-of-range read returns `rsp_rdata`=0 and `rsp_err`=1.
- Every request produces exactly one response, in acceptance order, carrying `rsp_write`, `rsp_rdata` and `rsp_err`.
- The response buffer pops on `rsp_valid`&&`rsp_ready`.
- Array contents are 0 at simulation start. Reset does not clear the array.
- Queue push and pop in the same cycle: `count` is unchanged.
- When `full`: `req_ready`=0 and there is no same-cycle push-through, even if a pop occurs.
- Queue pointers wrap modulo `QDEPTH`. `count` distinguishes full from empty.

## Timing
- Reset values: `req_ready`=1, `full`=0, `empty`=1, `count`=0, `rsp_valid`=0, `rsp_write`=0, `rsp_rdata`=0, `rsp_err`=0.
- Reset asserted mid-operation immediately flushes the queue, the pipeline and the response buffer. In-flight requests are dropped with no response. Writes already issued remain in the array.
- Minimum latency (`rsp_ready` held high): accept at edge E0, issue at E1, response written at E1+`RD_LAT`. `rsp_valid` is high in the cycle after that edge, giving `RD_LAT`+1 cycles from acceptance.
- Sustained throughput with `rsp_ready`=1: one request per cycle.
- A read issued at the cycle after a write issue to the same word observes the written data.
- `rsp_*` stay stable while `rsp_valid`&&!`rsp_ready`.

## Structure
- The shared package `snf_sram_pkg` holds the response field layout (write, err, data), the `clog2` function, and range-check constants.
- Sub-module `snf_sram_fifo`: parametrised width/depth synchronous FIFO with count, full and empty. It is instanced for the request queue and for the response buffer.
- The top level holds the array, the byte-enable merge, the `RD_LAT` shift pipeline, and the issue/credit logic.

## Test plan
- Reset then idle: all outputs equal their reset values. Release reset with no traffic: nothing changes.
- Write 0xA5.. to address 0x40 with all-ones byte enables, then read 0x40 (`RD_LAT`=1). Required: a write ack with `rsp_err`=0, then `rsp_rdata`=0xA5.., each `rsp_valid` 2 cycles after acceptance.
- Partial write with `req_be`=0x1 of 0xFF to a word holding 0. Read back: byte 0 = 0xFF, all other bytes 0.
- Hold `rsp_ready`=0 and push 8 requests. Required: `req_ready` drops after `RSP_DEPTH`+`QDEPTH` acceptances, with `full`=1 and `count`=4. Release `rsp_ready`: all responses arrive in order and nothing is lost.
- Read word index `DEPTH` and write word index `DEPTH`+1. Required: `rsp_err`=1 and `rsp_rdata`=0 for both, and array contents unchanged.
- Assert `rst`=0 with 3 requests queued. Required: outputs return to reset values immediately and no stale response appears after reset is released. A prior completed write still reads back correctly.

Source files
------------

// File: rtl/snf_sram_pkg.sv
// ============================================================================
// snf_sram_pkg : shared constants for the SNF SRAM model (response layout,
//                clog2 helper). Revision 1.0
// ============================================================================
`default_nettype none

package snf_sram_pkg;

    // Response word layout: {data, err, write}
    localparam int RSP_WRITE_BIT = 0;
    localparam int RSP_ERR_BIT   = 1;
    localparam int RSP_DATA_LSB  = 2;

    // Widest word index the range check ever needs to consider
    localparam int MAX_IDX_W     = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snf_sram_fifo.sv
// ============================================================================
// snf_sram_fifo : synchronous FIFO with occupancy count, full and empty.
//                 Push is refused while full, pop ignored while empty. Rev 1.0
// ============================================================================
`default_nettype none

module snf_sram_fifo
    import snf_sram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_rdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [clog2(DEPTH):0]     o_count
);

    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= f_next(r_wptr);
            if (w_do_pop)  r_rptr <= f_next(r_rptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/snf_sram_model.sv
// ============================================================================
// snf_sram_model : queued, word-addressed memory model with byte enables,
//                  fixed read latency and a credited response buffer. Rev 1.0
// ============================================================================
`default_nettype none

module snf_sram_model
    import snf_sram_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 44,
    parameter int DEPTH     = 64,
    parameter int QDEPTH    = 4,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [DATA_W/8-1:0]    req_be,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(QDEPTH):0] count
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF   = clog2(BE_W);
    localparam int IDX_W = clog2(DEPTH);
    localparam int REQ_W = 1 + ADDR_W + DATA_W + BE_W;
    localparam int RSP_W = RSP_DATA_LSB + DATA_W;
    localparam int OW    = clog2(RSP_DEPTH + RD_LAT + 1) + 1;

    logic [DATA_W-1:0]          r_mem [DEPTH];
    logic [RD_LAT-1:0]          r_pv;
    logic [RSP_W-1:0]           r_pd [RD_LAT];

    logic [REQ_W-1:0]           w_req_head;
    logic                       w_req_empty;
    logic                       w_h_write;
    logic [ADDR_W-1:0]          w_h_addr;
    logic [DATA_W-1:0]          w_h_wdata;
    logic [BE_W-1:0]            w_h_be;
    logic [IDX_W-1:0]           w_h_idx;
    logic                       w_h_inrange;
    logic                       w_issue;
    logic [RSP_W-1:0]           w_iss_rsp;
    logic [RSP_W-1:0]           w_rsp_head;
    logic                       w_rsp_empty;
    logic                       w_rsp_full;
    logic [clog2(RSP_DEPTH):0]  w_rsp_count;
    logic [OW-1:0]              w_outstanding;
    logic                       w_unused;

    snf_sram_fifo #(.WIDTH(REQ_W), .DEPTH(QDEPTH)) u_req_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_valid),
        .i_wdata ({req_write, req_addr, req_wdata, req_be}),
        .i_pop   (w_issue),
        .o_rdata (w_req_head),
        .o_full  (full),
        .o_empty (w_req_empty),
        .o_count (count)
    );

    assign req_ready   = !full;
    assign empty       = w_req_empty;

    assign w_h_write   = w_req_head[REQ_W-1];
    assign w_h_addr    = w_req_head[REQ_W-2 -: ADDR_W];
    assign w_h_wdata   = w_req_head[BE_W +: DATA_W];
    assign w_h_be      = w_req_head[BE_W-1:0];
    assign w_h_idx     = w_h_addr[OFF +: IDX_W];
    assign w_h_inrange = ~|w_h_addr[ADDR_W-1:OFF+IDX_W];
    assign w_unused    = ^{w_h_addr[OFF-1:0], w_rsp_full};

    // Every issued request holds a credit until its response leaves the
    // buffer, so the buffer can never overflow under back-pressure.
    always_comb begin
        w_outstanding = OW'(w_rsp_count);
        for (int i = 0; i < RD_LAT; i++) begin
            w_outstanding = w_outstanding + OW'(r_pv[i]);
        end
    end

    assign w_issue = !w_req_empty && (w_outstanding < OW'(RSP_DEPTH));

    always_comb begin
        w_iss_rsp                = '0;
        w_iss_rsp[RSP_WRITE_BIT] = w_h_write;
        w_iss_rsp[RSP_ERR_BIT]   = !w_h_inrange;
        if (!w_h_write && w_h_inrange) begin
            w_iss_rsp[RSP_DATA_LSB +: DATA_W] = r_mem[w_h_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue && w_h_write && w_h_inrange) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_h_be[b]) r_mem[w_h_idx][b*8 +: 8] <= w_h_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pd[i] <= '0;
        end else begin
            r_pv[0] <= w_issue;
            r_pd[0] <= w_iss_rsp;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    snf_sram_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pv[RD_LAT-1]),
        .i_wdata (r_pd[RD_LAT-1]),
        .i_pop   (rsp_valid && rsp_ready),
        .o_rdata (w_rsp_head),
        .o_full  (w_rsp_full),
        .o_empty (w_rsp_empty),
        .o_count (w_rsp_count)
    );

    // Fields are masked while idle so the outputs read as zero.
    assign rsp_valid = !w_rsp_empty;
    assign rsp_write = rsp_valid && w_rsp_head[RSP_WRITE_BIT];
    assign rsp_err   = rsp_valid && w_rsp_head[RSP_ERR_BIT];
    assign rsp_rdata = rsp_valid ? w_rsp_head[RSP_DATA_LSB +: DATA_W] : '0;

endmodule

`default_nettype wire
